// File: rtl/fadd_issue_arbiter.sv
// fadd_issue_arbiter: round-robin issue of NREQ requesters onto one shared
// pipelined FP add/sub unit, with ID tagging and in-order response return.
module fadd_issue_arbiter #(
  parameter int NREQ    = 4,
  parameter int LAT     = 5,
  parameter int MAX_OUT = 3,
  parameter int IDW     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [32*NREQ-1:0]       req_a,
  input  logic [32*NREQ-1:0]       req_b,
  input  logic [NREQ-1:0]          req_op,
  output logic [31:0]              fadd_a,
  output logic [31:0]              fadd_b,
  output logic                     fadd_op,
  input  logic [31:0]              fadd_result,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [31:0]              rsp_data,
  input  logic                     drain,
  output logic                     idle,
  output logic [$clog2(LAT+2)-1:0] busy_cnt
);

  localparam int SW = IDW + 1;
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int BW = $clog2(LAT + 2);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  logic [IDW-1:0]  ptr_q, ptr_d;
  tag_t            tag_q [LAT];
  tag_t            tag_d [LAT];
  logic [CW-1:0]   cnt_q [NREQ];
  logic [CW-1:0]   cnt_d [NREQ];
  logic [BW-1:0]   busy_q, busy_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic            op_q, op_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [31:0]     rsp_data_q, rsp_data_d;

  logic [NREQ-1:0] ret_hit;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] rdy;
  logic            grant;
  logic [IDW-1:0]  win;
  logic [SW-1:0]   pos;
  logic            pipe_any;

  // A response leaving this cycle frees its slot for a grant this cycle.
  always_comb begin
    ret_hit = '0;
    elig    = '0;
    for (int i = 0; i < NREQ; i++) begin
      ret_hit[i] = rsp_valid_q && (rsp_id_q == IDW'(i));
      elig[i]    = req_valid[i] && !drain && !rst &&
                   ((cnt_q[i] - CW'(ret_hit[i])) < CW'(MAX_OUT));
    end
  end

  always_comb begin
    grant = 1'b0;
    win   = '0;
    pos   = '0;
    for (int off = 0; off < NREQ; off++) begin
      pos = {1'b0, ptr_q} + SW'(off);
      if (pos >= SW'(NREQ)) pos = pos - SW'(NREQ);
      if (!grant && elig[pos[IDW-1:0]]) begin
        grant = 1'b1;
        win   = pos[IDW-1:0];
      end
    end
  end

  always_comb begin
    rdy  = '0;
    a_d  = '0;
    b_d  = '0;
    op_d = 1'b0;
    if (grant) rdy[win] = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (rdy[i]) begin
        a_d  = req_a[32*i +: 32];
        b_d  = req_b[32*i +: 32];
        op_d = req_op[i];
      end
    end
  end

  always_comb begin
    tag_d[0].vld = grant;
    tag_d[0].id  = win;
    for (int j = 1; j < LAT; j++) tag_d[j] = tag_q[j-1];
    rsp_valid_d = tag_q[LAT-1].vld;
    rsp_id_d    = tag_q[LAT-1].id;
    rsp_data_d  = fadd_result;
    pipe_any    = 1'b0;
    for (int j = 0; j < LAT; j++) pipe_any = pipe_any | tag_q[j].vld;
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++)
      cnt_d[i] = cnt_q[i] + CW'(rdy[i]) - CW'(ret_hit[i]);
    busy_d = busy_q + BW'(grant) - BW'(rsp_valid_q);
    ptr_d  = ptr_q;
    if (grant)
      ptr_d = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      busy_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      for (int j = 0; j < LAT; j++) tag_q[j] <= '0;
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      tag_q       <= tag_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready = rdy;
  assign fadd_a    = a_q;
  assign fadd_b    = b_q;
  assign fadd_op   = op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy_cnt  = busy_q;
  assign idle      = (busy_q == '0) && !pipe_any;

endmodule

// File: doc/fadd_issue_arbiter.md
Name: fadd_issue_arbiter

Overview:
- Shares one pipelined single-precision FP add/sub unit between NREQ requesters.
- Round-robin arbiter: at most one operation issued per cycle, registered onto the adder inputs.
- Tags each issued operation with its requester ID in a LAT-deep shift register, and returns the adder result to the issuing requester exactly LAT cycles later.
- Provides per-requester outstanding limits and a drain/quiesce control for the sequencer.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 5, cycles from adder inputs applied to adder result valid.
- MAX_OUT, 3, maximum in-flight operations per requester (1..LAT).
- IDW, 2, requester ID width, clog2(NREQ).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; transfer when valid&ready.
- req_a  input  32*NREQ  operand A, slice i = requester i.
- req_b  input  32*NREQ  operand B.
- req_op  input  NREQ  0 = add, 1 = subtract.
- fadd_a  output  32  to adder A.
- fadd_b  output  32  to adder B.
- fadd_op  output  1  to adder operation.
- fadd_result  input  32  from adder result.
- rsp_valid  output  1  response valid; single-cycle pulse, no backpressure.
- rsp_id  output  IDW  requester that owns rsp_data.
- rsp_data  output  32  result word (registered copy of fadd_result).
- drain  input  1  level; while high, no new grants.
- idle  output  1  high when no operation is in flight and no issue is pending.
- busy_cnt  output  clog2(LAT+2)  total operations in flight.

Behaviour:
- Reset values: req_ready = 0 during the rst cycle; fadd_a/fadd_b = 0; fadd_op = 0; rsp_valid = 0; rsp_id = 0; rsp_data = 0; idle = 1; busy_cnt = 0; RR pointer = 0; tag pipe cleared; outstanding counters = 0.
- Eligibility: requester i is eligible when req_valid[i], !drain, outstanding[i] < MAX_OUT and !rst.
- Arbitration:
  - Combinational round-robin: search starts at the RR pointer and picks the first eligible index upward, wrapping at NREQ-1 to 0.
  - req_ready is one-hot (or zero) and is asserted only for the winner; it never depends on req_valid of other requesters beyond eligibility.
  - On a grant to i, the pointer becomes (i+1) mod NREQ. With no grant, the pointer holds.
- Issue (cycle k handshake):
  - fadd_a/b/op are registered with the winner's operands, visible in cycle k+1.
  - Tag {1, i} enters tag_pipe[0].
  - With no grant, fadd_a/b/op are driven to 0 and a bubble tag {0, x} enters.
- Tag pipe:
  - LAT entries, shifting every cycle with no stall; the adder has no stall input.
  - A tag leaving the last entry aligns with fadd_result for the operands issued LAT cycles earlier.
- Response:
  - rsp_valid, rsp_id and rsp_data are registered from the tag-pipe output and fadd_result.
  - rsp_valid pulses in cycle k+1+LAT relative to handshake cycle k. Total accept-to-response latency = LAT+1.
- Outstanding counters:
  - Per requester: +1 on its grant, -1 on its rsp_valid, unchanged when both occur in the same cycle.
  - busy_cnt is the sum, maintained incrementally.
  - Counters must never exceed MAX_OUT or underflow.
- Drain:
  - Asserting drain blocks grants in that same cycle. In-flight operations still complete.
  - idle = (busy_cnt == 0) and no tag valid in the pipe.
  - Deasserting drain resumes arbitration from the held pointer.
- Throughput: a single requester with MAX_OUT < LAT+1 is throttled to MAX_OUT operations per LAT+1 cycles. Multiple requesters together sustain 1 operation per cycle.
- Reset mid-operation:
  - All tags, counters and pointer clear, and no rsp_valid follows for operations issued before reset.
  - The adder shares rst, and its residual outputs are ignored because no valid tag exists.
- Operand contents (NaN, Inf, denormal) pass through untouched; special-case handling belongs to the adder.

Test Plan:
- Single op: requester 0 issues A=0x3F800000, B=0x40000000, op=0 at cycle 10 → fadd_a/fadd_b driven in cycle 11; rsp_valid=1, rsp_id=0, rsp_data=0x40400000 in cycle 16 (LAT=5).
- Round-robin: all four requesters hold valid continuously from reset release → grant order 0,1,2,3,0,1…, one issue per cycle; responses return in the same order with matching IDs and operands (A=i, B=1.0 encodings).
- Outstanding limit: only requester 2 is valid with MAX_OUT=3 → 3 consecutive grants, then req_ready[2]=0 until its first response; the 4th grant lands in the same cycle as the first rsp_valid.
- Drain: drain raised with 4 ops in flight → no req_ready while high; exactly 4 responses arrive, then idle=1 and busy_cnt=0; after drain drops, the next grant goes to the pointer position.
- Subtract and bypass values: op=1, A=0x40400000, B=0x3F800000 → rsp_data=0x40000000; A=0x7F800000 (+Inf), B=1.0 → rsp_data=0x7F800000, routed to the correct rsp_id.
- Reset mid-flight: rst asserted for 1 cycle with 3 ops in flight → no rsp_valid for those ops in the following LAT+1 cycles; all counters are 0; a fresh request afterwards completes normally.
